// File: rtl/fp_matcher_if.sv
// fp_matcher_if: sensor-side and lock-control-side signal bundle for fp_matcher.
// master: the block driving fingerprints and enrollment commands.
// slave: the matcher itself.
interface fp_matcher_if #(
  parameter int unsigned FP_W     = 8,
  parameter int unsigned BTN_W    = 4,
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned MAX_FAIL = 3
);
  localparam int unsigned SW = $clog2(SLOTS);
  localparam int unsigned CW = $clog2(MAX_FAIL + 1);

  // Fingerprint presentation handshake
  logic             fp_valid;
  logic             fp_ready;
  logic [FP_W-1:0]  fp_in;
  logic [BTN_W-1:0] btn_in;

  // Template management
  logic             enroll_req;
  logic [SW-1:0]    enroll_slot;
  logic             clear_req;

  // Result and status
  logic             done;
  logic             mismatch;
  logic [SW-1:0]    match_slot;
  logic [BTN_W-1:0] num;
  logic             locked;
  logic [CW-1:0]    fail_cnt;

  modport master (
    output fp_valid, fp_in, btn_in, enroll_req, enroll_slot, clear_req,
    input  fp_ready, done, mismatch, match_slot, num, locked, fail_cnt
  );

  modport slave (
    input  fp_valid, fp_in, btn_in, enroll_req, enroll_slot, clear_req,
    output fp_ready, done, mismatch, match_slot, num, locked, fail_cnt
  );
endinterface

// File: rtl/fp_matcher.sv
// fp_matcher: multi-slot fingerprint matcher with enrollment and failed-attempt lockout.
// Scans SLOTS stored templates one per cycle after each accepted fingerprint and reports
// the first hit. Define FP_LOCKOUT_EN to build the LOCKED state and its timer; without it
// locked is tied low and RESULT always returns to IDLE.
module fp_matcher #(
  parameter int unsigned FP_W        = 8,
  parameter int unsigned BTN_W       = 4,
  parameter int unsigned SLOTS       = 4,
  parameter int unsigned DEFAULT_FP  = 97,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input logic          clk,
  input logic          rst_n,
  fp_matcher_if.slave  bus
);

  localparam int unsigned SW = $clog2(SLOTS);
  localparam int unsigned CW = $clog2(MAX_FAIL + 1);

  localparam logic [SW-1:0]   LastIdx   = SW'(SLOTS - 1);
  localparam logic [CW-1:0]   MaxFail   = CW'(MAX_FAIL);
  localparam logic [FP_W-1:0] DefaultFp = FP_W'(DEFAULT_FP);

  // Reject configurations the scan and lockout logic cannot honour
  if (SLOTS < 2 || MAX_FAIL < 1 || LOCK_CYCLES < 1) begin : g_param_check
    $error("fp_matcher: SLOTS must be >= 2, MAX_FAIL and LOCK_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    StIdle,
    StCompare,
    StResult,
    StLocked
  } state_e;

  state_e            state_q;
  logic [FP_W-1:0]   stored_q [SLOTS];
  logic [SLOTS-1:0]  valid_q;
  logic [FP_W-1:0]   fp_q;
  logic [SW-1:0]     idx_q;
  logic              done_q;
  logic              mismatch_q;
  logic [SW-1:0]     match_slot_q;
  logic [BTN_W-1:0]  num_q;
  logic [CW-1:0]     fail_cnt_q;

`ifdef FP_LOCKOUT_EN
  localparam int unsigned TW       = $clog2(LOCK_CYCLES + 1);
  localparam logic [TW-1:0] LockLast = TW'(LOCK_CYCLES - 1);

  logic              locked_q;
  logic [TW-1:0]     timer_q;
`endif

  logic              fp_ready;
  logic              in_idle;
  logic              hit;
  logic [CW-1:0]     fail_next;

  // Handshake, slot comparison and saturating miss count
  always_comb begin
    in_idle   = (state_q == StIdle);
    // Clear and enroll take the IDLE cycle, so a simultaneous fingerprint is not accepted
    fp_ready  = in_idle && !bus.clear_req && !bus.enroll_req;
    hit       = valid_q[idx_q] && (stored_q[idx_q] == fp_q);
    fail_next = (fail_cnt_q == MaxFail) ? fail_cnt_q : fail_cnt_q + CW'(1);
  end

  // Template table: clear beats enroll, both only honoured in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SLOTS); i++) begin
        stored_q[i] <= '0;
      end
      stored_q[0] <= DefaultFp;
      valid_q     <= SLOTS'(1);
    end else if (in_idle) begin
      if (bus.clear_req) begin
        valid_q <= '0;
      end else if (bus.enroll_req && (int'(bus.enroll_slot) < int'(SLOTS))) begin
        stored_q[bus.enroll_slot] <= bus.fp_in;
        valid_q[bus.enroll_slot]  <= 1'b1;
      end
    end
  end

  // Control FSM with registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      fp_q         <= '0;
      idx_q        <= '0;
      done_q       <= 1'b0;
      mismatch_q   <= 1'b1;
      match_slot_q <= '0;
      num_q        <= '0;
      fail_cnt_q   <= '0;
`ifdef FP_LOCKOUT_EN
      locked_q     <= 1'b0;
      timer_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.fp_valid && fp_ready) begin
            fp_q    <= bus.fp_in;
            num_q   <= bus.btn_in;
            idx_q   <= '0;
            state_q <= StCompare;
          end
        end

        StCompare: begin
          // First valid match wins, so a duplicate template reports the lowest slot
          if (hit || (idx_q == LastIdx)) begin
            done_q       <= 1'b1;
            mismatch_q   <= !hit;
            match_slot_q <= hit ? idx_q : '0;
            fail_cnt_q   <= hit ? '0 : fail_next;
            state_q      <= StResult;
          end else begin
            idx_q <= idx_q + SW'(1);
          end
        end

        StResult: begin
`ifdef FP_LOCKOUT_EN
          // fail_cnt already holds this attempt's count
          if (fail_cnt_q == MaxFail) begin
            locked_q <= 1'b1;
            timer_q  <= '0;
            state_q  <= StLocked;
          end else begin
            state_q <= StIdle;
          end
`else
          state_q <= StIdle;
`endif
        end

        StLocked: begin
`ifdef FP_LOCKOUT_EN
          // All requests are dropped here; leave after exactly LOCK_CYCLES cycles
          if (timer_q == LockLast) begin
            locked_q   <= 1'b0;
            fail_cnt_q <= '0;
            state_q    <= StIdle;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
`else
          state_q <= StIdle;
`endif
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.fp_ready   = fp_ready;
  assign bus.done       = done_q;
  assign bus.mismatch   = mismatch_q;
  assign bus.match_slot = match_slot_q;
  assign bus.num        = num_q;
  assign bus.fail_cnt   = fail_cnt_q;
`ifdef FP_LOCKOUT_EN
  assign bus.locked     = locked_q;
`else
  assign bus.locked     = 1'b0;
`endif

endmodule

// File: tb/tb_fp_matcher.sv
// tb_fp_matcher: table-driven checks of fp_matcher plus directed lockout, clear and
// reset-during-scan sequences. Works with FP_LOCKOUT_EN defined or undefined.
module tb_fp_matcher;

  localparam int unsigned FP_W  = 8;
  localparam int unsigned BTN_W = 4;
  localparam int unsigned SLOTS = 4;
  localparam int unsigned MAXF  = 3;
  localparam int unsigned LOCKC = 16;

  localparam int OpPresent = 0;
  localparam int OpEnroll  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fp_matcher_if #(.FP_W(FP_W), .BTN_W(BTN_W), .SLOTS(SLOTS), .MAX_FAIL(MAXF)) bus ();

  fp_matcher #(
    .FP_W(FP_W), .BTN_W(BTN_W), .SLOTS(SLOTS), .DEFAULT_FP(97),
    .MAX_FAIL(MAXF), .LOCK_CYCLES(LOCKC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int         op;
    logic [7:0] fp;
    logic [3:0] btn;
    int         slot;
    int         lat;
    int         mm;
    int         mslot;
    int         fail;
  } vec_t;

  vec_t vecs[13];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic enroll(input logic [7:0] fp, input int slot);
    @(negedge clk);
    bus.enroll_req  = 1'b1;
    bus.fp_in       = fp;
    bus.enroll_slot = 2'(slot);
    #1 check("enroll_ready_low", int'(bus.fp_ready), 0);
    @(posedge clk);
    #1 bus.enroll_req = 1'b0;
  endtask

  // Present one fingerprint and check result latency and outputs at the done cycle
  task automatic present(input string tag, input logic [7:0] fp, input logic [3:0] btn,
                         input int exp_lat, input int exp_mm, input int exp_slot,
                         input int exp_fail);
    int lat;
    lat = 0;
    @(negedge clk);
    bus.fp_valid = 1'b1;
    bus.fp_in    = fp;
    bus.btn_in   = btn;
    #1 check({tag, "_ready"}, int'(bus.fp_ready), 1);
    @(posedge clk);
    #1 bus.fp_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, "_busy"}, int'(bus.fp_ready), 0);
      if (bus.done) begin
        lat = c;
        break;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_mismatch"}, int'(bus.mismatch), exp_mm);
    check({tag, "_slot"}, int'(bus.match_slot), exp_slot);
    check({tag, "_num"}, int'(bus.num), int'(btn));
    check({tag, "_fail_cnt"}, int'(bus.fail_cnt), exp_fail);
    check({tag, "_locked"}, int'(bus.locked), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lk, bad_rdy, bad_done, dn;

    bus.fp_valid    = 1'b0;
    bus.fp_in       = '0;
    bus.btn_in      = '0;
    bus.enroll_req  = 1'b0;
    bus.enroll_slot = '0;
    bus.clear_req   = 1'b0;

    //           op         fp     btn  slot lat mm mslot fail
    vecs[0]  = '{OpPresent, 8'd97, 4'd5, 0, 2, 0, 0, 0};
    vecs[1]  = '{OpEnroll,  8'h3C, 4'd0, 2, 0, 0, 0, 0};
    vecs[2]  = '{OpPresent, 8'h3C, 4'd9, 0, 4, 0, 2, 0};
    vecs[3]  = '{OpPresent, 8'h55, 4'd3, 0, 5, 1, 0, 1};
    vecs[4]  = '{OpPresent, 8'd97, 4'd1, 0, 2, 0, 0, 0};
    vecs[5]  = '{OpEnroll,  8'h77, 4'd0, 3, 0, 0, 0, 0};
    vecs[6]  = '{OpPresent, 8'h77, 4'd15, 0, 5, 0, 3, 0};
    vecs[7]  = '{OpEnroll,  8'h3C, 4'd0, 1, 0, 0, 0, 0};
    vecs[8]  = '{OpPresent, 8'h3C, 4'd2, 0, 3, 0, 1, 0};
    vecs[9]  = '{OpEnroll,  8'hAA, 4'd0, 2, 0, 0, 0, 0};
    vecs[10] = '{OpPresent, 8'hAA, 4'd7, 0, 4, 0, 2, 0};
    vecs[11] = '{OpPresent, 8'h3D, 4'd4, 0, 5, 1, 0, 1};
    vecs[12] = '{OpPresent, 8'd97, 4'd0, 0, 2, 0, 0, 0};

    // Reset values while reset is held
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", int'(bus.fp_ready), 1);
    check("rst_done", int'(bus.done), 0);
    check("rst_mismatch", int'(bus.mismatch), 1);
    check("rst_slot", int'(bus.match_slot), 0);
    check("rst_num", int'(bus.num), 0);
    check("rst_locked", int'(bus.locked), 0);
    check("rst_fail_cnt", int'(bus.fail_cnt), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].op == OpEnroll) begin
        enroll(vecs[i].fp, vecs[i].slot);
      end else begin
        present($sformatf("vec%0d", i), vecs[i].fp, vecs[i].btn, vecs[i].lat, vecs[i].mm,
                vecs[i].mslot, vecs[i].fail);
      end
    end

    // Three consecutive misses from a fresh reset
    pulse_reset();
    present("miss1", 8'h11, 4'd8, 5, 1, 0, 1);
    present("miss2", 8'h11, 4'd8, 5, 1, 0, 2);
    present("miss3", 8'h11, 4'd8, 5, 1, 0, 3);
`ifdef FP_LOCKOUT_EN
    lk = 0;
    bad_rdy = 0;
    bad_done = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!bus.locked) break;
      lk++;
      if (bus.fp_ready) bad_rdy++;
      if (bus.done) bad_done++;
      if (lk <= 5) begin
        bus.fp_valid    = 1'b1;
        bus.enroll_req  = 1'b1;
        bus.enroll_slot = 2'd1;
        bus.fp_in       = 8'h11;
      end else begin
        bus.fp_valid   = 1'b0;
        bus.enroll_req = 1'b0;
      end
    end
    check("lock_cycles", lk, int'(LOCKC));
    check("lock_ready_high", bad_rdy, 0);
    check("lock_done_seen", bad_done, 0);
    check("unlock_ready", int'(bus.fp_ready), 1);
    check("unlock_fail_cnt", int'(bus.fail_cnt), 0);
    // Enroll during lockout was dropped, so 0x11 still misses
    present("post_lock_miss", 8'h11, 4'd2, 5, 1, 0, 1);
    present("post_lock_hit", 8'd97, 4'd3, 2, 0, 0, 0);
`else
    @(negedge clk);
    check("nolock_locked", int'(bus.locked), 0);
    check("nolock_ready", int'(bus.fp_ready), 1);
    present("miss4_sat", 8'h11, 4'd8, 5, 1, 0, 3);
    present("hit_clears", 8'd97, 4'd3, 2, 0, 0, 0);
`endif

    // clear_req beats a simultaneous fp_valid
    @(negedge clk);
    bus.clear_req = 1'b1;
    bus.fp_valid  = 1'b1;
    bus.fp_in     = 8'd97;
    #1 check("clear_ready_low", int'(bus.fp_ready), 0);
    @(posedge clk);
    #1;
    bus.clear_req = 1'b0;
    bus.fp_valid  = 1'b0;
    dn = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.done) dn++;
    end
    check("clear_no_accept", dn, 0);
    check("clear_ready_back", int'(bus.fp_ready), 1);
    present("after_clear", 8'd97, 4'd3, 5, 1, 0, 1);

    // Asynchronous reset in the middle of a scan
    @(negedge clk);
    bus.fp_valid = 1'b1;
    bus.fp_in    = 8'h42;
    bus.btn_in   = 4'hA;
    @(posedge clk);
    #1 bus.fp_valid = 1'b0;
    @(posedge clk);
    #1 check("scan_num", int'(bus.num), 10);
    check("scan_busy", int'(bus.fp_ready), 0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", int'(bus.fp_ready), 1);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_mismatch", int'(bus.mismatch), 1);
    check("midrst_slot", int'(bus.match_slot), 0);
    check("midrst_num", int'(bus.num), 0);
    check("midrst_fail_cnt", int'(bus.fail_cnt), 0);
    check("midrst_locked", int'(bus.locked), 0);
    @(negedge clk);
    rst_n = 1'b1;
    present("after_rst", 8'd97, 4'd6, 2, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
